// File: rtl/seq_10110_framer_if.sv
// Word handshake plus serial-output bundle for seq_10110_framer.
// The master offers payload words; the slave is the framer itself.
interface seq_10110_framer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              data_out;
    logic              frame_active;
    logic              stuff_flag;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, data_out, frame_active, stuff_flag
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, data_out, frame_active, stuff_flag
    );
endinterface

// File: rtl/seq_10110_framer.sv
// Serial framer: sync 10110, MSB-first payload, stuffing keeps 10110 unique to sync.
// Define TX_PARITY_EN to append an even-parity bit after the payload.
module seq_10110_framer #(
    parameter int DATA_W = 8,
    parameter int GAP    = 1
) (
    input  logic              clk,
    input  logic              rst,
    seq_10110_framer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_PAR,
        S_GAP
    } state_t;

    localparam int            CW        = 6;
    localparam logic [4:0]    SYNC_W    = 5'b10110;
    localparam logic [3:0]    HAZARD    = 4'b1011;
    localparam logic [CW-1:0] SYNC_LAST = CW'(4);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [3:0]        hist_q;
    logic              dout_q;
    logic              act_q;
    logic              stuff_q;
`ifdef TX_PARITY_EN
    logic              par_q;
`endif

    logic              bit_d;
    logic              act_d;
    logic              stuff_d;
    logic              accept;
    logic              hazard;
    logic [2:0]        sync_idx;

    assign bus.tx_ready     = (state_q == S_IDLE);
    assign bus.data_out     = dout_q;
    assign bus.frame_active = act_q;
    assign bus.stuff_flag   = stuff_q;

    assign accept   = bus.tx_valid & bus.tx_ready;
    assign hazard   = (hist_q == HAZARD);
    assign sync_idx = 3'd4 - cnt_q[2:0];

    // Bit to drive next; a hazard history turns the pending bit into a stuffed 1.
    always_comb begin
        bit_d   = 1'b0;
        act_d   = 1'b0;
        stuff_d = 1'b0;
        unique case (state_q)
            S_SYNC: begin
                bit_d = SYNC_W[sync_idx];
                act_d = 1'b1;
            end
            S_DATA: begin
                act_d   = 1'b1;
                stuff_d = hazard;
                bit_d   = hazard | shift_q[DATA_W-1];
            end
`ifdef TX_PARITY_EN
            S_PAR: begin
                act_d   = 1'b1;
                stuff_d = hazard;
                bit_d   = hazard | par_q;
            end
`endif
            S_GAP: begin
                act_d   = hazard;
                stuff_d = hazard;
                bit_d   = hazard;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            hist_q  <= '0;
            dout_q  <= 1'b0;
            act_q   <= 1'b0;
            stuff_q <= 1'b0;
`ifdef TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            dout_q  <= bit_d;
            act_q   <= act_d;
            stuff_q <= stuff_d;
            hist_q  <= {hist_q[2:0], bit_d};
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q <= S_SYNC;
                        cnt_q   <= '0;
                        shift_q <= bus.tx_data;
`ifdef TX_PARITY_EN
                        par_q   <= ^bus.tx_data;
`endif
                    end
                end
                S_SYNC: begin
                    if (cnt_q == SYNC_LAST) begin
                        state_q <= S_DATA;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (!hazard) begin
                        shift_q <= shift_q << 1;
                        if (cnt_q == DATA_LAST) begin
                            cnt_q <= '0;
`ifdef TX_PARITY_EN
                            state_q <= S_PAR;
`else
                            state_q <= S_GAP;
`endif
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
`ifdef TX_PARITY_EN
                S_PAR: begin
                    if (!hazard) begin
                        state_q <= S_GAP;
                        cnt_q   <= '0;
                    end
                end
`endif
                S_GAP: begin
                    if (!hazard) begin
                        if (cnt_q == GAP_LAST) begin
                            state_q <= S_IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_10110_framer.sv
// Scoreboard bench for seq_10110_framer: directed frames, abort, random back-to-back.
// Honours TX_PARITY_EN the same way the design does.
module tb_seq_10110_framer;
    localparam int DATA_W = 8;
    localparam int GAP    = 1;

    logic clk = 1'b0;
    logic rst;

    seq_10110_framer_if #(.DATA_W(DATA_W)) bus ();

    seq_10110_framer #(
        .DATA_W(DATA_W),
        .GAP   (GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec     = 0;
    int nerr     = 0;
    int n_det    = 0;
    int n_frames = 0;

    // {data_out, stuff_flag} per expected frame bit, and frame lengths
    logic [1:0] exp_q[$];
    int         len_q[$];

    logic [4:0] mon_win;
    int         mon_cur;
    bit         mon_in;

    logic [7:0] dw [5] = '{8'h00, 8'hC0, 8'h0B, 8'h01, 8'h03};
`ifdef TX_PARITY_EN
    string ds [5] = '{"10110000000000", "1011011S0000000", "1011000001011S1",
                      "10110000000011", "10110000000110"};
`else
    string ds [5] = '{"1011000000000", "1011011S000000", "1011000001011S",
                      "1011000000001", "1011000000011"};
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string info);
        nvec++;
        nerr++;
        $display("FAIL %s: %s (cycle %0d)", name, info, cyc);
    endtask

    // Reference: build the frame as a list (0/1, 2 = stuffed 1) from the framing rules.
    function automatic void push_model(input logic [DATA_W-1:0] w, output int len);
        int         bits[$];
        int         src[$];
        logic [3:0] h;
        bits = '{1, 0, 1, 1, 0};
        for (int i = DATA_W - 1; i >= 0; i--) src.push_back(int'(w[i]));
`ifdef TX_PARITY_EN
        src.push_back(int'(^w));
`endif
        src.push_back(-1);
        foreach (src[k]) begin
            h = 4'b0000;
            for (int j = bits.size() - 4; j < bits.size(); j++) h = {h[2:0], bits[j] != 0};
            if (h == 4'b1011) bits.push_back(2);
            if (src[k] >= 0) bits.push_back(src[k]);
        end
        foreach (bits[k]) exp_q.push_back(bits[k] == 2 ? 2'b11 : (bits[k] == 1 ? 2'b10 : 2'b00));
        len = bits.size();
        len_q.push_back(len);
    endfunction

    function automatic void push_str(input string s, output int len);
        byte c;
        for (int k = 0; k < s.len(); k++) begin
            c = s[k];
            exp_q.push_back(c == "S" ? 2'b11 : (c == "1" ? 2'b10 : 2'b00));
        end
        len = s.len();
        len_q.push_back(len);
    endfunction

    task automatic send(input logic [DATA_W-1:0] w, input bit hold,
                        output int acc, output bit ok);
        int t;
        t   = 0;
        acc = 0;
        @(negedge clk);
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        while (!bus.tx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        ok = bus.tx_ready;
        if (!ok) begin
            fail("accept_timeout", "tx_ready never rose");
            bus.tx_valid = 1'b0;
            return;
        end
        acc = cyc;
        n_frames++;
        @(posedge clk);
        #1;
        if (!hold) bus.tx_valid = 1'b0;
        bus.tx_data = DATA_W'($urandom);
    endtask

    // Monitor: pops expectations on frame bits, checks idle, runs a 10110 detector.
    initial begin
        logic [1:0] e;
        mon_win = '0;
        mon_cur = 0;
        mon_in  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_win = '0;
                mon_cur = 0;
                mon_in  = 1'b0;
            end else begin
                mon_win = {mon_win[3:0], bus.data_out};
                if (bus.frame_active) begin
                    if (exp_q.size() == 0) begin
                        fail("extra_bit", "frame bit with empty scoreboard");
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_bit", 32'({bus.data_out, bus.stuff_flag}), 32'(e));
                    end
                    if (mon_win == 5'b10110) begin
                        n_det++;
                        chk("detect_pos", 32'(mon_cur), 32'd4);
                    end
                    mon_cur++;
                    mon_in = 1'b1;
                end else begin
                    chk("idle_bits", 32'({bus.data_out, bus.stuff_flag}), 32'd0);
                    if (mon_win == 5'b10110) fail("idle_detect", "10110 outside a frame");
                    if (mon_in) begin
                        if (len_q.size() == 0) fail("frame_len", "unexpected frame end");
                        else chk("frame_len", 32'(mon_cur), 32'(len_q.pop_front()));
                        mon_cur = 0;
                        mon_in  = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int               len;
        int               prev_len;
        int               acc;
        int               prev_acc;
        int               t;
        bit               ok;
        logic [DATA_W-1:0] w;

        prev_len     = 0;
        prev_acc     = 0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        rst          = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data_out", 32'(bus.data_out), 32'd0);
        chk("rst_frame_active", 32'(bus.frame_active), 32'd0);
        chk("rst_stuff_flag", 32'(bus.stuff_flag), 32'd0);
        chk("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        rst = 1'b1;

        // abort on the third payload bit
        push_model(8'hA5, len);
        send(8'hA5, 1'b0, acc, ok);
        repeat (8) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_data_out", 32'(bus.data_out), 32'd0);
        chk("abort_frame_active", 32'(bus.frame_active), 32'd0);
        chk("abort_tx_ready", 32'(bus.tx_ready), 32'd1);
        exp_q.delete();
        len_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            push_str(ds[i], len);
            send(dw[i], 1'b0, acc, ok);
        end

        for (int i = 0; i < 20; i++) begin
            w = DATA_W'($urandom);
            push_model(w, len);
            send(w, 1'b1, acc, ok);
            if (i > 0 && ok) chk("accept_spacing", 32'(acc - prev_acc), 32'(prev_len + GAP + 1));
            prev_acc = acc;
            prev_len = len;
        end
        bus.tx_valid = 1'b0;

        t = 0;
        while ((exp_q.size() != 0 || bus.frame_active) && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (GAP + 3) @(negedge clk);
        chk("drain_bits", 32'(exp_q.size()), 32'd0);
        chk("drain_frames", 32'(len_q.size()), 32'd0);
        chk("detections", 32'(n_det), 32'(n_frames));
        chk("end_tx_ready", 32'(bus.tx_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/seq_10110_framer.md
# seq_10110_framer

Serial frame transmitter that generates the bit stream consumed by the overlapping 10110 sequence detector. It accepts a parallel word over a valid/ready handshake and shifts out one bit per clock: the 5-bit sync word 10110, then the payload MSB-first, with optional parity. Bit stuffing keeps 10110 out of the payload, parity and trailing idle. A downstream detector therefore fires exactly once per frame, on the sync word.

## Interface
- DATA_W, 8: payload width in bits; legal range 1..32.
- GAP, 1: number of idle-zero bits forced after every frame; legal range 1..15.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- tx_data  input  DATA_W  payload word; sampled only on an accepted handshake.
- tx_valid  input  1  payload request.
- tx_ready  output  1  high only in IDLE.
- data_out  output  1  registered serial bit; 0 whenever no frame is active.
- frame_active  output  1  registered; high while data_out carries a sync, payload, parity or stuff bit.
- stuff_flag  output  1  registered; high while data_out carries an inserted stuff bit.

## Operation
- Reset while rst=0: state IDLE, data_out=0, frame_active=0, stuff_flag=0, tx_ready=1, bit history=0000. Reset takes effect immediately, including mid-frame (frame aborted, nothing resumes).
- Handshake: accept occurs on a rising edge with tx_valid=1 and tx_ready=1. tx_data is latched into the shift register on that edge. tx_ready is a decode of state==IDLE.
- States and transitions:
  - IDLE: data_out=0. Accept -> SYNC.
  - SYNC: emits 1,0,1,1,0 over 5 cycles, then -> DATA.
  - DATA: emits DATA_W bits MSB-first. After the last bit -> PAR if TX_PARITY_EN is defined, else -> GAP.
  - PAR: emits 1 bit, then -> GAP.
  - GAP: data_out=0 for GAP cycles, then -> IDLE.
- Bit history: a 4-bit register holding the last four bits actually driven on data_out, including sync and stuff bits.
- Stuffing rule:
  - Applies before each DATA bit, before the PAR bit, and before entering GAP.
  - If history==1011, emit a 1 instead, with stuff_flag=1 and frame_active=1.
  - The bit pointer and state are held during the stuff cycle, so the pending bit goes out next cycle.
  - The rule is never applied inside SYNC.
- Guarantee: 10110 appears in the output stream only as the sync word, including across sync/payload and frame/idle boundaries.
- Frame length: 5 + DATA_W + P + S bits. P=1 if parity is compiled in, else 0. S is the stuff count, at most ceil((DATA_W+P+1)/3).

## Timing
- Accept at edge N -> first sync bit (1) on data_out from edge N+1. One bit per cycle thereafter, with no bubbles except stuff bits.
- The last frame bit is followed by exactly GAP zeros. tx_ready rises in the cycle after the last GAP bit.
- Back-to-back: with tx_valid held high, the next sync begins GAP+1 cycles after the last frame bit.
- tx_valid or tx_data changes outside an accept edge have no effect.
- An abort by rst mid-frame leaves data_out=0. A partial sync sequence cannot complete 10110 because idle is all zeros.

## Configuration
- TX_PARITY_EN defined: after the payload, emit one even-parity bit, equal to the XOR of all DATA_W payload bits. The parity bit is subject to the stuffing rule.
- TX_PARITY_EN undefined: no PAR state. Frames go directly from DATA to GAP.

## Test plan
- Reset: assert rst=0 at the 3rd payload bit of a frame -> data_out=0, frame_active=0, tx_ready=1 immediately; after release, the next accept starts a fresh sync.
- tx_data=8'h00, GAP=1, no parity -> data_out sequence 1,0,1,1,0, then 0 x8, then 0 gap; 13 frame bits; stuff_flag never set.
- tx_data=8'hC0 -> data_out 1,0,1,1,0,1,1,[1 stuffed],0,0,0,0,0,0; 14 frame bits; stuff_flag high on bit 8 only.
- tx_data=8'h0B -> payload 0,0,0,0,1,0,1,1 followed by a trailing stuffed 1 before the gap zero; frame_active falls after the stuff bit.
- 20 random words back-to-back, tx_valid held high, output fed to a reference overlapping 10110 detector -> exactly 20 detections, each on the cycle after the sync word's final 0; accepts spaced frame length + GAP + 1 cycles apart.
- TX_PARITY_EN defined, tx_data=8'h01 -> parity bit 1 after the payload, no stuff; tx_data=8'h03 -> parity 0, frame length 14.
